imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage; successor to the combinational immediate extender.
- Takes the full 32-bit instruction and an immediate-select code, and produces an XLEN-wide extended immediate.
- Supports two new modes, CSR zimm and shift amount, plus an illegal-select error flag.
- Sits between fetch/decode and the register-read stage, behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure never creates a combinational ready path.

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each immediate.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries (branch mispredict / trap).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  block can accept an entry this cycle.
- in_instr  input  32  raw instruction.
- in_immsrc  input  3  immediate select code.
- in_tag  input  TAG_W  sideband data, passed through unchanged.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the entry.
- out_immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag matching out_immext.
- out_err  output  1  in_immsrc was 3'b111 (illegal select).

Behaviour:
- Decode (combinational, applied on input), with i = in_instr; "sext" means sign-extend from i[31] to XLEN:
  - 000 I: sext(i[31:20]).
  - 001 S: sext({i[31:25], i[11:7]}).
  - 010 B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - 011 J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - 100 U: {i[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
  - 101 Z: zero-extend i[19:15].
  - 110 SHAMT: zero-extend i[25:20] when XLEN=64, i[24:20] when XLEN=32.
  - 111: immext = 0, err = 1.
  - err = 0 for all other codes.
- Storage:
  - Main output register (valid, immext, tag, err) drives the out_* ports directly.
  - Skid register holds the same fields.
- in_ready = !skid_valid, driven from a register only.
- Transfer rules:
  - A transfer in or out occurs when valid && ready are both high at the rising edge.
  - On input transfer with the main register empty, or being drained this cycle (out_ready=1), the decoded entry loads the main register.
  - On input transfer with the main register full and out_ready=0, the entry loads the skid register; skid_valid goes to 1.
  - On output transfer with skid_valid=1, the skid entry moves to the main register and skid_valid goes to 0, in the same cycle.
  - An input transfer in that same cycle is impossible, because in_ready=0.
- Latency: 1 cycle from input transfer to out_valid when unstalled. Throughput: 1 entry per cycle with out_ready held high.
- Ordering: strictly FIFO; there is no reordering path.
- Output stability: while out_valid=1 and out_ready=0, out_immext, out_tag and out_err hold stable.
- Flush:
  - The next edge clears main valid and skid_valid.
  - An input presented in the flush cycle is discarded.
  - in_ready is 1 in the following cycle.
- Reset:
  - out_valid=0, skid_valid=0, in_ready=1, out_immext=0, out_tag=0, out_err=0.
  - Reset mid-stall discards both entries.
  - rst has priority over flush, and flush has priority over the handshake.
- Data-register contents do not matter when valid=0, except that they are 0 after reset.
- in_immsrc and in_instr values are ignored when in_valid=0. X on those inputs must not propagate into valid state.

Test Plan:
- XLEN=32, I-type instr 0xFFF00093 with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_immext=0xFFFFFFFF, out_err=0.
- Back-to-back stream of five instructions, out_ready=1, all on consecutive cycles:
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0xFE000CE3 -> 0xFFFFFFF8.
  - J 0x0010006F -> 0x00000800.
  - U 0x123452B7 -> 0x12345000.
  - Z with instr[19:15]=11111 -> 0x0000001F.
  - Required: outputs appear in order, one per cycle, no bubbles.
- Stall case: out_ready=0 while three entries with tags 1, 2, 3 are offered.
  - Tags 1 and 2 are accepted; in_ready drops to 0 after the second.
  - Tag 3 is held upstream.
  - Raise out_ready -> tags 1, 2, 3 emerge in order, with no loss or duplication.
- XLEN=64 cases:
  - U 0x800002B7 -> 0xFFFFFFFF80000000.
  - SHAMT with instr[25:20]=6'b111111 -> 0x000000000000003F.
  - immsrc 111 -> out_immext=0, out_err=1.
- Flush and reset with both entries full:
  - Assert flush -> next cycle out_valid=0, in_ready=1.
  - Repeat with rst instead of flush -> all outputs at reset values; the first post-reset input emerges after 1 cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered immediate generator for the decode stage. It takes a raw 32-bit
// instruction and an immediate-select code, decodes the XLEN-wide immediate,
// and hands it downstream together with a sideband tag (normally the PC)
// behind a valid/ready handshake.
//
// A 2-entry skid buffer (main output register + skid register) decouples the
// two handshakes. in_ready comes straight from a flop, so downstream
// back-pressure never forms a combinational path to upstream.
//
// Immediate select codes:
//   000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110 SHAMT,
//   111 illegal (immediate forced to 0, err flag set)
//
// Parameters:
//   XLEN   output datapath width, 32 or 64
//   TAG_W  sideband tag width
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   flush       drop every buffered entry and the entry offered this cycle
//   in_valid    upstream entry valid
//   in_ready    block can accept an entry this cycle (registered)
//   in_instr    raw 32-bit instruction
//   in_immsrc   immediate select code
//   in_tag      sideband data, passed through unchanged
//   out_valid   output entry valid
//   out_ready   downstream accepts the entry
//   out_immext  extended immediate
//   out_tag     tag belonging to out_immext
//   out_err     entry was decoded with the illegal select code
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  // Build the immediate at 64 bits and keep the low XLEN bits. Every format
  // sign-extends from bit 31 (or zero-extends), so truncating the 64-bit
  // result gives exactly the XLEN=32 value, including U (which is then just
  // {i[31:12], 12'b0}).
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] i,
                                                 input logic [2:0]  sel);
    logic [63:0] imm64;
    case (sel)
      3'b000: imm64 = {{52{i[31]}}, i[31:20]};
      3'b001: imm64 = {{52{i[31]}}, i[31:25], i[11:7]};
      3'b010: imm64 = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011: imm64 = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'b100: imm64 = {{32{i[31]}}, i[31:12], 12'b0};
      3'b101: imm64 = {59'd0, i[19:15]};
      3'b110: imm64 = (XLEN == 64) ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
      3'b111: imm64 = 64'd0;
      default: imm64 = 64'd0;
    endcase
    return imm64[XLEN-1:0];
  endfunction

  // Opcode bits never feed an immediate; fold them into a named sink.
  logic unused_opcode_s;
  assign unused_opcode_s = ^in_instr[6:0];

  // Storage: main register drives the outputs, skid register absorbs the one
  // entry that can arrive while main is full and stalled.
  logic             main_valid_r, main_err_r;
  logic [XLEN-1:0]  main_imm_r;
  logic [TAG_W-1:0] main_tag_r;
  logic             skid_valid_r, skid_err_r;
  logic [XLEN-1:0]  skid_imm_r;
  logic [TAG_W-1:0] skid_tag_r;
  logic             in_ready_r;

  logic             main_valid_nxt_s, main_err_nxt_s;
  logic [XLEN-1:0]  main_imm_nxt_s;
  logic [TAG_W-1:0] main_tag_nxt_s;
  logic             skid_valid_nxt_s, skid_err_nxt_s;
  logic [XLEN-1:0]  skid_imm_nxt_s;
  logic [TAG_W-1:0] skid_tag_nxt_s;
  logic             in_ready_nxt_s;

  logic             in_xfer_s, out_xfer_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic             dec_err_s;

  // Decode the offered instruction; only consumed on an input transfer, so
  // X on the data inputs with in_valid low never reaches valid state.
  always_comb begin
    dec_imm_s = decode_imm(in_instr, in_immsrc);
    dec_err_s = (in_immsrc == 3'b111);
  end

  // Handshake qualifiers.
  always_comb begin
    in_xfer_s  = in_valid & in_ready_r;
    out_xfer_s = main_valid_r & out_ready;
  end

  // Next-state for the two-entry buffer. Flush beats the handshake. A skid
  // refill and an input transfer never coincide because in_ready is low
  // whenever the skid register is occupied.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    main_imm_nxt_s   = main_imm_r;
    main_tag_nxt_s   = main_tag_r;
    main_err_nxt_s   = main_err_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_imm_nxt_s   = skid_imm_r;
    skid_tag_nxt_s   = skid_tag_r;
    skid_err_nxt_s   = skid_err_r;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (out_xfer_s && skid_valid_r) begin
      main_valid_nxt_s = 1'b1;
      main_imm_nxt_s   = skid_imm_r;
      main_tag_nxt_s   = skid_tag_r;
      main_err_nxt_s   = skid_err_r;
      skid_valid_nxt_s = 1'b0;
    end else if (in_xfer_s && (!main_valid_r || out_ready)) begin
      main_valid_nxt_s = 1'b1;
      main_imm_nxt_s   = dec_imm_s;
      main_tag_nxt_s   = in_tag;
      main_err_nxt_s   = dec_err_s;
    end else if (in_xfer_s) begin
      skid_valid_nxt_s = 1'b1;
      skid_imm_nxt_s   = dec_imm_s;
      skid_tag_nxt_s   = in_tag;
      skid_err_nxt_s   = dec_err_s;
    end else if (out_xfer_s) begin
      main_valid_nxt_s = 1'b0;
    end else begin
      main_valid_nxt_s = main_valid_r;
    end
    in_ready_nxt_s = ~skid_valid_nxt_s;
  end

  // State registers with synchronous reset clearing valids and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_imm_r   <= '0;
      main_tag_r   <= '0;
      main_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_imm_r   <= '0;
      skid_tag_r   <= '0;
      skid_err_r   <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      main_imm_r   <= main_imm_nxt_s;
      main_tag_r   <= main_tag_nxt_s;
      main_err_r   <= main_err_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_imm_r   <= skid_imm_nxt_s;
      skid_tag_r   <= skid_tag_nxt_s;
      skid_err_r   <= skid_err_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_immext = main_imm_r;
  assign out_tag    = main_tag_r;
  assign out_err    = main_err_r;

endmodule
